// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control unit.
// A single state register walks each instruction through FETCH, DECODE and its
// execution states. The datapath controls are decoded combinationally from the
// current state and mem_ready.
// Handshake: mem_ready is sampled only in FETCH, MEMRD and MEMWR. A cycle with
// mem_ready=1 completes the access, and the FSM advances on that clock edge.
// A cycle with mem_ready=0 holds the state and keeps the access strobes asserted.
module multicycle_control #(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 2,
    parameter int EN_JUMP  = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          pc_source,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic [3:0]          state,
    output logic                illegal
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_IEXEC  = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [5:0] w_op6;
    logic       w_hi_zero;
    logic       w_is_rtype;
    logic       w_is_lw;
    logic       w_is_sw;
    logic       w_is_beq;
    logic       w_is_addi;
    logic       w_is_j;
    logic [1:0] w_alu_op2;

    // Opcode classification: any set bit above bit 5 makes the opcode illegal.
    assign w_op6      = opcode[5:0];
    assign w_hi_zero  = ((opcode >> 6) == '0);
    assign w_is_rtype = w_hi_zero && (w_op6 == 6'b000000);
    assign w_is_lw    = w_hi_zero && (w_op6 == 6'b100011);
    assign w_is_sw    = w_hi_zero && (w_op6 == 6'b101011);
    assign w_is_beq   = w_hi_zero && (w_op6 == 6'b000100);
    assign w_is_addi  = w_hi_zero && (w_op6 == 6'b001000);
    assign w_is_j     = w_hi_zero && (w_op6 == 6'b000010) && (EN_JUMP != 0);

    // Next-state selection. Unused state codes fall into TRAP.
    always_comb begin
        w_next = S_TRAP;
        case (r_state)
            S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (w_is_rtype)              w_next = S_EXEC;
                else if (w_is_lw || w_is_sw) w_next = S_MEMADR;
                else if (w_is_beq)           w_next = S_BRANCH;
                else if (w_is_addi)          w_next = S_IEXEC;
                else if (w_is_j)             w_next = S_JUMP;
                else                         w_next = S_TRAP;
            end
            S_MEMADR: w_next = w_is_sw ? S_MEMWR : S_MEMRD;
            S_MEMRD:  w_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  w_next = S_FETCH;
            S_MEMWR:  w_next = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   w_next = S_RWB;
            S_RWB:    w_next = S_FETCH;
            S_BRANCH: w_next = S_FETCH;
            S_IEXEC:  w_next = S_IWB;
            S_IWB:    w_next = S_FETCH;
            S_JUMP:   w_next = S_FETCH;
            S_TRAP:   w_next = S_TRAP;
            default:  w_next = S_TRAP;
        endcase
    end

    // State register. Reset forces FETCH without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    // Control decode. Every output is held at 0 while reset is high.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_source     = 2'b00;
        w_alu_op2     = 2'b00;
        illegal       = 1'b0;
        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: alu_src_b = 2'b11;
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEMWR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    w_alu_op2 = 2'b10;
                end
                S_RWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    w_alu_op2     = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                end
                S_IEXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_IWB:  reg_write = 1'b1;
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                end
                S_TRAP:  illegal = 1'b1;
                default: illegal = 1'b0;
            endcase
        end
    end

    assign alu_op = ALUOP_W'(w_alu_op2);
    assign state  = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control. It instantiates the default configuration
// and a wide configuration (OPCODE_W=8, ALUOP_W=3, EN_JUMP=0).
// The driver pushes one hand-computed output word per cycle.
// A negedge monitor pops and compares each word.
module tb_multicycle_control;

  // Word layout: state[21:18] illegal[17]
  // {pc_write,pc_write_cond,i_or_d,mem_read,mem_write,ir_write,mem_to_reg,reg_dst,reg_write,alu_src_a}[16:7]
  // alu_src_b[6:5] pc_source[4:3] alu_op[2:0]
  localparam logic [21:0] E_RST     = {4'd0,  1'b0, 10'b0000000000, 2'b00, 2'b00, 3'b000};
  localparam logic [21:0] E_FETCH_W = {4'd0,  1'b0, 10'b0001000000, 2'b01, 2'b00, 3'b000};
  localparam logic [21:0] E_FETCH_R = {4'd0,  1'b0, 10'b1001010000, 2'b01, 2'b00, 3'b000};
  localparam logic [21:0] E_DECODE  = {4'd1,  1'b0, 10'b0000000000, 2'b11, 2'b00, 3'b000};
  localparam logic [21:0] E_MEMADR  = {4'd2,  1'b0, 10'b0000000001, 2'b10, 2'b00, 3'b000};
  localparam logic [21:0] E_MEMRD   = {4'd3,  1'b0, 10'b0011000000, 2'b00, 2'b00, 3'b000};
  localparam logic [21:0] E_MEMWB   = {4'd4,  1'b0, 10'b0000001010, 2'b00, 2'b00, 3'b000};
  localparam logic [21:0] E_MEMWR   = {4'd5,  1'b0, 10'b0010100000, 2'b00, 2'b00, 3'b000};
  localparam logic [21:0] E_EXEC    = {4'd6,  1'b0, 10'b0000000001, 2'b00, 2'b00, 3'b010};
  localparam logic [21:0] E_RWB     = {4'd7,  1'b0, 10'b0000000110, 2'b00, 2'b00, 3'b000};
  localparam logic [21:0] E_BRANCH  = {4'd8,  1'b0, 10'b0100000001, 2'b00, 2'b01, 3'b001};
  localparam logic [21:0] E_IEXEC   = {4'd9,  1'b0, 10'b0000000001, 2'b10, 2'b00, 3'b000};
  localparam logic [21:0] E_IWB     = {4'd10, 1'b0, 10'b0000000010, 2'b00, 2'b00, 3'b000};
  localparam logic [21:0] E_JUMP    = {4'd11, 1'b0, 10'b1000000000, 2'b00, 2'b10, 3'b000};
  localparam logic [21:0] E_TRAP    = {4'd12, 1'b1, 10'b0000000000, 2'b00, 2'b00, 3'b000};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reset8 = 1'b1;
  logic        mem_ready = 1'b0;
  logic [5:0]  opcode = '0;
  logic [7:0]  opcode8 = '0;
  logic        sel = 1'b0;

  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
  logic [1:0]  alu_src_b, pc_source, alu_op;
  logic [3:0]  state;

  logic        pc_write8, pc_write_cond8, i_or_d8, mem_read8, mem_write8, ir_write8;
  logic        mem_to_reg8, reg_dst8, reg_write8, alu_src_a8, illegal8;
  logic [1:0]  alu_src_b8, pc_source8;
  logic [2:0]  alu_op8;
  logic [3:0]  state8;

  logic [21:0] obs6, obs8;

  logic [21:0] exp_q[$];
  string       name_q[$];
  int          n_total = 0;
  int          n_pass  = 0;

  // clock / reset
  always #5 clk = ~clk;

  multicycle_control u_dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .alu_op(alu_op), .state(state), .illegal(illegal)
  );

  multicycle_control #(.OPCODE_W(8), .ALUOP_W(3), .EN_JUMP(0)) u_dut8 (
    .clk(clk), .reset(reset8), .opcode(opcode8), .mem_ready(mem_ready),
    .pc_write(pc_write8), .pc_write_cond(pc_write_cond8), .i_or_d(i_or_d8),
    .mem_read(mem_read8), .mem_write(mem_write8), .ir_write(ir_write8),
    .mem_to_reg(mem_to_reg8), .reg_dst(reg_dst8), .reg_write(reg_write8),
    .alu_src_a(alu_src_a8), .alu_src_b(alu_src_b8), .pc_source(pc_source8),
    .alu_op(alu_op8), .state(state8), .illegal(illegal8)
  );

  assign obs6 = {state, illegal, pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                 ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
                 pc_source, 1'b0, alu_op};
  assign obs8 = {state8, illegal8, pc_write8, pc_write_cond8, i_or_d8, mem_read8, mem_write8,
                 ir_write8, mem_to_reg8, reg_dst8, reg_write8, alu_src_a8, alu_src_b8,
                 pc_source8, alu_op8};

  // driver: s selects the DUT under test, and the other DUT is held in reset
  task automatic step(input string nm, input logic s, input logic rs, input logic mr,
                      input logic [7:0] op, input logic [21:0] exp);
    @(posedge clk);
    #1;
    sel       = s;
    reset     = s ? 1'b1 : rs;
    reset8    = s ? rs : 1'b1;
    mem_ready = mr;
    opcode    = op[5:0];
    opcode8   = op;
    exp_q.push_back(exp);
    name_q.push_back(nm);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [21:0] e;
    logic [21:0] o;
    string       n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      o = sel ? obs8 : obs6;
      n_total = n_total + 1;
      if (o !== e)
        $display("FAIL %s: got %h expected %h (t=%0t)", n, o, e, $time);
      else
        n_pass = n_pass + 1;
    end
  end

  initial begin
    #3;
    // reset held with mem_ready=1: all controls 0, state FETCH
    step("rst_hold", 0, 1, 1, 8'h00, E_RST);
    // lw, zero wait: 0,1,2,3,4,0
    step("lw_fetch",  0, 0, 1, 8'h23, E_FETCH_R);
    step("lw_decode", 0, 0, 1, 8'h23, E_DECODE);
    step("lw_memadr", 0, 0, 1, 8'h23, E_MEMADR);
    step("lw_memrd",  0, 0, 1, 8'h23, E_MEMRD);
    step("lw_memwb",  0, 0, 1, 8'h23, E_MEMWB);
    // fetch wait 3 cycles, then beq: 0,1,8,0
    step("fw_w1",      0, 0, 0, 8'h04, E_FETCH_W);
    step("fw_w2",      0, 0, 0, 8'h04, E_FETCH_W);
    step("fw_w3",      0, 0, 0, 8'h04, E_FETCH_W);
    step("fw_r",       0, 0, 1, 8'h04, E_FETCH_R);
    step("beq_decode", 0, 0, 0, 8'h04, E_DECODE);
    step("beq_branch", 0, 0, 0, 8'h04, E_BRANCH);
    // sw with two wait cycles in MEMWR
    step("sw_fetch",  0, 0, 1, 8'h2B, E_FETCH_R);
    step("sw_decode", 0, 0, 1, 8'h2B, E_DECODE);
    step("sw_memadr", 0, 0, 0, 8'h2B, E_MEMADR);
    step("sw_wr_w1",  0, 0, 0, 8'h2B, E_MEMWR);
    step("sw_wr_w2",  0, 0, 0, 8'h2B, E_MEMWR);
    step("sw_wr_r",   0, 0, 1, 8'h2B, E_MEMWR);
    // R-type with mem_ready low outside the memory states
    step("r_fetch",  0, 0, 1, 8'h00, E_FETCH_R);
    step("r_decode", 0, 0, 0, 8'h00, E_DECODE);
    step("r_exec",   0, 0, 0, 8'h00, E_EXEC);
    step("r_rwb",    0, 0, 0, 8'h00, E_RWB);
    // addi
    step("addi_fetch",  0, 0, 1, 8'h08, E_FETCH_R);
    step("addi_decode", 0, 0, 1, 8'h08, E_DECODE);
    step("addi_iexec",  0, 0, 1, 8'h08, E_IEXEC);
    step("addi_iwb",    0, 0, 1, 8'h08, E_IWB);
    // j with EN_JUMP=1
    step("j_fetch",  0, 0, 1, 8'h02, E_FETCH_R);
    step("j_decode", 0, 0, 1, 8'h02, E_DECODE);
    step("j_jump",   0, 0, 1, 8'h02, E_JUMP);
    // lw wait in MEMRD, then reset mid-wait
    step("lwr_fetch",  0, 0, 1, 8'h23, E_FETCH_R);
    step("lwr_decode", 0, 0, 1, 8'h23, E_DECODE);
    step("lwr_memadr", 0, 0, 1, 8'h23, E_MEMADR);
    step("lwr_wait",   0, 0, 0, 8'h23, E_MEMRD);
    step("lwr_rst",    0, 1, 0, 8'h23, E_RST);
    step("lwr_fetch2", 0, 0, 0, 8'h3F, E_FETCH_W);
    // illegal 111111 traps and holds for 10 cycles
    step("ill_fetch",  0, 0, 1, 8'h3F, E_FETCH_R);
    step("ill_decode", 0, 0, 1, 8'h3F, E_DECODE);
    for (int i = 0; i < 10; i++)
      step($sformatf("trap_hold%0d", i), 0, 0, 1'(i % 2), 8'h00, E_TRAP);
    // reset pulse: cleared before any clock edge
    step("trap_rst",   0, 1, 1, 8'h00, E_RST);
    step("post_trap",  0, 0, 1, 8'h00, E_FETCH_R);
    // wide instance: upper opcode bit set -> TRAP
    step("w_rst",      1, 1, 1, 8'h40, E_RST);
    step("w_fetch",    1, 0, 1, 8'h40, E_FETCH_R);
    step("w_decode",   1, 0, 1, 8'h40, E_DECODE);
    step("w_trap",     1, 0, 1, 8'h00, E_TRAP);
    step("w_trap_rst", 1, 1, 1, 8'h00, E_RST);
    // wide instance: R-type -> EXEC with 3-bit alu_op 010
    step("w_r_fetch",  1, 0, 1, 8'h00, E_FETCH_R);
    step("w_r_decode", 1, 0, 1, 8'h00, E_DECODE);
    step("w_r_exec",   1, 0, 1, 8'h00, E_EXEC);
    step("w_r_rwb",    1, 0, 1, 8'h00, E_RWB);
    // wide instance: j with EN_JUMP=0 -> TRAP
    step("w_j_fetch",  1, 0, 1, 8'h02, E_FETCH_R);
    step("w_j_decode", 1, 0, 1, 8'h02, E_DECODE);
    step("w_j_trap",   1, 0, 1, 8'h02, E_TRAP);
    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_total = n_total + 1;
      $display("FAIL drain: %0d expected words left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // global time bound
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
